// File: rtl/sys_update_ctrl.sv
// Command sequencer for a remote-update IP: accepts one command at a time, issues a
// single-cycle strobe, tracks the IP busy handshake with bounded waits and reports completion.
module sys_update_ctrl #(
    parameter int unsigned BUSY_START_CYC = 4,
    parameter int unsigned TIMEOUT_CYC    = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_param,
    input  logic [1:0]  cmd_src,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  ru_param,
    output logic [1:0]  ru_read_source,
    output logic [31:0] ru_data_in,
    output logic        ru_read_param,
    output logic        ru_write_param,
    output logic        ru_reconfig,
    output logic        ru_reset_timer,
    input  logic        ru_busy,
    input  logic [31:0] ru_data_out
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ISSUE      = 3'd1;
    localparam logic [2:0] WAIT_START = 3'd2;
    localparam logic [2:0] WAIT_END   = 3'd3;
    localparam logic [2:0] CAPTURE    = 3'd4;

    localparam logic [1:0] OP_READ        = 2'd0;
    localparam logic [1:0] OP_WRITE       = 2'd1;
    localparam logic [1:0] OP_RECONFIG    = 2'd2;
    localparam logic [1:0] OP_RESET_TIMER = 2'd3;

    // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
    localparam logic [15:0] START_LAST   = (BUSY_START_CYC > 1) ? 16'(BUSY_START_CYC - 1) : 16'd0;
    localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT_CYC > 1)    ? 16'(TIMEOUT_CYC - 1)    : 16'd0;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic [1:0]  op_q;
    logic [2:0]  param_q;
    logic [1:0]  src_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        issue;
    logic [31:0] capture_rdata;

    // Ready is masked by reset so it reads 0 during reset and 1 as soon as reset drops.
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    tmo_d   = 1'b0;
                end
            end
            ISSUE: state_d = WAIT_START;
            WAIT_START: begin
                if (ru_busy) begin
                    state_d = WAIT_END;
                end else if (cnt_q >= START_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_END: begin
                // Busy dropping wins over a simultaneous timeout.
                if (!ru_busy) begin
                    state_d = CAPTURE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = CAPTURE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign issue          = (state_q == ISSUE);
    assign ru_read_param  = issue && (op_q == OP_READ);
    assign ru_write_param = issue && (op_q == OP_WRITE);
    assign ru_reconfig    = issue && (op_q == OP_RECONFIG);
    assign ru_reset_timer = issue && (op_q == OP_RESET_TIMER);

    assign ru_param       = param_q;
    assign ru_read_source = src_q;
    assign ru_data_in     = wdata_q;

    // The response is shown live during CAPTURE and held in registers afterwards.
    assign rsp_valid     = (state_q == CAPTURE);
    assign capture_rdata = (op_q == OP_READ) ? ru_data_out : 32'h0;
    assign rsp_rdata     = rsp_valid ? capture_rdata : rdata_q;
    assign rsp_err       = rsp_valid ? tmo_q : err_q;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            op_q    <= '0;
            param_q <= '0;
            src_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            if (accept) begin
                op_q    <= cmd_op;
                param_q <= cmd_param;
                src_q   <= cmd_src;
                wdata_q <= cmd_wdata;
            end
            if (rsp_valid) begin
                rdata_q <= capture_rdata;
                err_q   <= tmo_q;
            end
        end
    end

endmodule

// File: tb/tb_sys_update_ctrl.sv
// Directed bench for sys_update_ctrl: latency, strobes, busy timeout and its boundary,
// reset behaviour and back-to-back command handling.
module tb_sys_update_ctrl;

    localparam int BSC = 4;
    localparam int TOC = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_param = '0;
    logic [1:0]  cmd_src = '0;
    logic [31:0] cmd_wdata = '0;
    logic        ru_busy = 1'b0;
    logic [31:0] ru_data_out = '0;

    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  ru_param;
    logic [1:0]  ru_read_source;
    logic [31:0] ru_data_in;
    logic        ru_read_param;
    logic        ru_write_param;
    logic        ru_reconfig;
    logic        ru_reset_timer;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_rc = 0, n_rt = 0, n_rv = 0, n_multi = 0;

    sys_update_ctrl #(
        .BUSY_START_CYC(BSC),
        .TIMEOUT_CYC   (TOC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_param     (cmd_param),
        .cmd_src       (cmd_src),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .ru_param      (ru_param),
        .ru_read_source(ru_read_source),
        .ru_data_in    (ru_data_in),
        .ru_read_param (ru_read_param),
        .ru_write_param(ru_write_param),
        .ru_reconfig   (ru_reconfig),
        .ru_reset_timer(ru_reset_timer),
        .ru_busy       (ru_busy),
        .ru_data_out   (ru_data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle; tasks compare deltas across a command.
    always @(negedge clock) begin
        n_rd <= n_rd + int'(ru_read_param === 1'b1);
        n_wr <= n_wr + int'(ru_write_param === 1'b1);
        n_rc <= n_rc + int'(ru_reconfig === 1'b1);
        n_rt <= n_rt + int'(ru_reset_timer === 1'b1);
        n_rv <= n_rv + int'(rsp_valid === 1'b1);
        if ((int'(ru_read_param === 1'b1) + int'(ru_write_param === 1'b1) +
             int'(ru_reconfig === 1'b1) + int'(ru_reset_timer === 1'b1)) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Presents a command and returns one cycle after acceptance (ISSUE cycle, post-edge).
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] prm, input logic [1:0] src,
                          input logic [31:0] wd, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_param = prm;
        cmd_src = src;
        cmd_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                done = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept: op %0d not accepted within 20 cycles", op);
        end
    endtask

    // Returns at the negedge of the rsp_valid cycle; also tracks ru_data_in stability.
    task automatic wait_rsp(input logic [31:0] exp_din, output int rc, output bit din_ok);
        bit got;
        got = 1'b0;
        rc = -1;
        din_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (ru_data_in !== exp_din) din_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                rc = cyc;
                got = 1'b1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_wait: no rsp_valid within 40 cycles");
        end
    endtask

    task automatic test_reset;
        logic [11:0] ctl;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        ctl = {cmd_ready, rsp_valid, rsp_err, ru_read_param, ru_write_param, ru_reconfig,
               ru_reset_timer, ru_param, ru_read_source};
        checks++;
        if (ctl !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctl: got %h expected 000", ctl);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || ru_data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata %h data_in %h expected 0", rsp_rdata, ru_data_in);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_read;
        int acc, rc, s_rd, s_wr, s_rv;
        bit din_ok;
        ru_busy = 1'b0;
        ru_data_out = 32'hA5A5_0001;
        s_rd = n_rd; s_wr = n_wr; s_rv = n_rv;
        do_cmd(2'd0, 3'd5, 2'd1, 32'h0, acc);
        @(negedge clock);
        checks++;
        if (ru_read_param !== 1'b1 || ru_param !== 3'd5 || ru_read_source !== 2'd1) begin
            errors++;
            $display("FAIL read_issue: strobe %b param %0d src %0d expected 1 5 1",
                     ru_read_param, ru_param, ru_read_source);
        end
        tick();
        ru_busy = 1'b1;
        tick();
        tick();
        tick();
        ru_busy = 1'b0;
        wait_rsp(32'h0, rc, din_ok);
        checks++;
        if (rc - acc !== 6) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 6", rc - acc);
        end
        checks++;
        if (rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: rdata %h err %b expected a5a50001 0", rsp_rdata, rsp_err);
        end
        tick();
        tick();
        checks++;
        if (n_rd - s_rd !== 1 || n_wr - s_wr !== 0 || n_rv - s_rv !== 1) begin
            errors++;
            $display("FAIL read_pulses: rd %0d wr %0d rsp %0d expected 1 0 1",
                     n_rd - s_rd, n_wr - s_wr, n_rv - s_rv);
        end
        checks++;
        if (ru_param !== 3'd5 || rsp_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL read_hold: param %0d rdata %h expected 5 a5a50001", ru_param, rsp_rdata);
        end
    endtask

    task automatic test_write;
        int acc, rc, s_wr, s_rd, s_rv;
        bit din_ok;
        ru_busy = 1'b0;
        s_wr = n_wr; s_rd = n_rd; s_rv = n_rv;
        do_cmd(2'd1, 3'd2, 2'd0, 32'h0000_1234, acc);
        wait_rsp(32'h0000_1234, rc, din_ok);
        checks++;
        if (rc - acc !== 2 + BSC) begin
            errors++;
            $display("FAIL write_latency: got %0d expected %0d", rc - acc, 2 + BSC);
        end
        checks++;
        if (!din_ok) begin
            errors++;
            $display("FAIL write_data_in: ru_data_in %h not held at 00001234", ru_data_in);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: rdata %h err %b expected 0 0", rsp_rdata, rsp_err);
        end
        tick();
        tick();
        checks++;
        if (n_wr - s_wr !== 1 || n_rd - s_rd !== 0 || n_rv - s_rv !== 1) begin
            errors++;
            $display("FAIL write_pulses: wr %0d rd %0d rsp %0d expected 1 0 1",
                     n_wr - s_wr, n_rd - s_rd, n_rv - s_rv);
        end
    endtask

    task automatic test_ops;
        int acc, rc, s_rd, s_wr, s_rc, s_rt;
        bit din_ok;
        ru_busy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_rd = n_rd; s_wr = n_wr; s_rc = n_rc; s_rt = n_rt;
            do_cmd((k == 0) ? 2'd2 : 2'd3, 3'd0, 2'd0, 32'h0, acc);
            wait_rsp(32'h0, rc, din_ok);
            tick();
            tick();
            checks++;
            if (n_rd - s_rd !== 0 || n_wr - s_wr !== 0 ||
                n_rc - s_rc !== ((k == 0) ? 1 : 0) || n_rt - s_rt !== ((k == 0) ? 0 : 1)) begin
                errors++;
                $display("FAIL ops_pulses[%0d]: rd %0d wr %0d rc %0d rt %0d", k,
                         n_rd - s_rd, n_wr - s_wr, n_rc - s_rc, n_rt - s_rt);
            end
        end
    endtask

    task automatic test_timeout;
        int acc, rc;
        bit din_ok;
        ru_busy = 1'b1;
        do_cmd(2'd1, 3'd1, 2'd0, 32'h0, acc);
        wait_rsp(32'h0, rc, din_ok);
        checks++;
        if (rc - acc !== 3 + TOC) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", rc - acc, 3 + TOC);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: err %b rdata %h expected 1 0", rsp_err, rsp_rdata);
        end
        repeat (3) tick();
        @(negedge clock);
        checks++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: err %b valid %b ready %b expected 1 0 1",
                     rsp_err, rsp_valid, cmd_ready);
        end
        tick();
        ru_busy = 1'b0;
        ru_data_out = 32'h1111_2222;
        do_cmd(2'd0, 3'd3, 2'd2, 32'h0, acc);
        wait_rsp(32'h0, rc, din_ok);
        checks++;
        if (rc - acc !== 2 + BSC || rsp_err !== 1'b0 || rsp_rdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL after_timeout: lat %0d err %b rdata %h expected %0d 0 11112222",
                     rc - acc, rsp_err, rsp_rdata, 2 + BSC);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int acc, s_all, s_rv;
        logic [11:0] ctl;
        ru_busy = 1'b1;
        do_cmd(2'd0, 3'd6, 2'd2, 32'hDEAD_BEEF, acc);
        repeat (4) tick();
        s_rv = n_rv;
        reset = 1'b1;
        tick();
        @(negedge clock);
        ctl = {cmd_ready, rsp_valid, rsp_err, ru_read_param, ru_write_param, ru_reconfig,
               ru_reset_timer, ru_param, ru_read_source};
        checks++;
        if (ctl !== 12'h000 || rsp_rdata !== 32'h0 || ru_data_in !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ctl %h rdata %h data_in %h expected all 0",
                     ctl, rsp_rdata, ru_data_in);
        end
        tick();
        reset = 1'b0;
        ru_busy = 1'b0;
        s_all = n_rd + n_wr + n_rc + n_rt;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b expected 1", cmd_ready);
        end
        repeat (25) tick();
        checks++;
        if (n_rv - s_rv !== 0 || n_rd + n_wr + n_rc + n_rt - s_all !== 0) begin
            errors++;
            $display("FAIL midreset_abort: rsp %0d strobes %0d expected 0 0",
                     n_rv - s_rv, n_rd + n_wr + n_rc + n_rt - s_all);
        end
    endtask

    task automatic test_timeout_boundary;
        int acc, rc;
        bit din_ok;
        ru_busy = 1'b1;
        do_cmd(2'd1, 3'd0, 2'd0, 32'h0, acc);
        repeat (17) tick();
        ru_busy = 1'b0;
        wait_rsp(32'h0, rc, din_ok);
        checks++;
        if (rc - acc !== 3 + TOC || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_boundary: lat %0d err %b expected %0d 0", rc - acc, rsp_err, 3 + TOC);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0] ops [3];
        int acc [3];
        int k, nrsp, s_rd, s_wr, s_rc, s_rt;
        bit accepted;
        ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd2;
        k = 0;
        nrsp = 0;
        ru_busy = 1'b0;
        s_rd = n_rd; s_wr = n_wr; s_rc = n_rc; s_rt = n_rt;
        cmd_valid = 1'b1;
        cmd_op = ops[0];
        for (int i = 0; i < 60 && nrsp < 3; i++) begin
            @(negedge clock);
            accepted = 1'b0;
            if (cmd_ready === 1'b1 && k < 3) begin
                acc[k] = cyc;
                k++;
                accepted = 1'b1;
            end
            if (rsp_valid === 1'b1) nrsp++;
            tick();
            if (accepted) begin
                if (k < 3) cmd_op = ops[k];
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (k !== 3 || nrsp !== 3) begin
            errors++;
            $display("FAIL b2b_count: accepts %0d rsps %0d expected 3 3", k, nrsp);
        end
        checks++;
        if (k == 3 && (acc[1] - acc[0] !== 3 + BSC || acc[2] - acc[1] !== 3 + BSC)) begin
            errors++;
            $display("FAIL b2b_spacing: %0d %0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], 3 + BSC);
        end
        checks++;
        if (n_rd - s_rd !== 1 || n_wr - s_wr !== 1 || n_rc - s_rc !== 1 || n_rt - s_rt !== 0) begin
            errors++;
            $display("FAIL b2b_pulses: rd %0d wr %0d rc %0d rt %0d expected 1 1 1 0",
                     n_rd - s_rd, n_wr - s_wr, n_rc - s_rc, n_rt - s_rt);
        end
    endtask

    task automatic test_onehot;
        checks++;
        if (n_multi !== 0) begin
            errors++;
            $display("FAIL strobe_onehot: %0d cycles with several strobes, expected 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_ops();
        test_timeout();
        test_reset_mid();
        test_timeout_boundary();
        test_back_to_back();
        test_onehot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
